apb_txn_scheduler: RTL and testbench
====================================

Name: apb_txn_scheduler

Overview:
- Transaction-aware APB scheduler. Shares one downstream APB master port between NUM_MASTERS core-side APB requesters.
- Sits between the cores' APB master outputs and the single-master APB interconnect input.
- Runs a proper SETUP/ACCESS phase sequence with round-robin fairness and registered address/data capture.
- A per-transfer timeout keeps a hung slave from locking the bus.

Parameters:
- NUM_MASTERS, 4, number of requesting APB masters; must be at least 1.
- BUS_WIDTH, 16, APB address width.
- DATA_WIDTH, 16, APB data width.
- TIMEOUT, 255, ACCESS-phase cycle limit before abort; 0 disables the timeout.
- CNT_WIDTH, 8, width of the timeout counter; must satisfy TIMEOUT < 2**CNT_WIDTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- S_PADDR  in  NUM_MASTERS*BUS_WIDTH  per-master address.
- S_PWRITE  in  NUM_MASTERS  per-master write strobe.
- S_PSELx  in  NUM_MASTERS  per-master request (PSEL).
- S_PENABLE  in  NUM_MASTERS  per-master PENABLE; observed but not forwarded.
- S_PWDATA  in  NUM_MASTERS*DATA_WIDTH  per-master write data.
- S_PRDATA  out  NUM_MASTERS*DATA_WIDTH  read data, valid only in the granted slice.
- S_PREADY  out  NUM_MASTERS  one-cycle completion pulse to the granted master.
- S_PSLVERR  out  NUM_MASTERS  timeout-abort flag; same cycle as S_PREADY.
- M_PADDR  out  BUS_WIDTH  latched address.
- M_PWRITE  out  1  latched write strobe.
- M_PSEL  out  1  downstream select.
- M_PENABLE  out  1  downstream enable.
- M_PWDATA  out  DATA_WIDTH  latched write data.
- M_PRDATA  in  DATA_WIDTH  downstream read data.
- M_PREADY  in  1  downstream ready.
- grants  out  NUM_MASTERS  one-hot current owner; all zeros when idle.

Behaviour:
- Clock and reset: single clock domain, clock port clk. Reset port reset is asynchronous and active-low; assertion clears all state immediately, regardless of clock.
- Reset values: state=IDLE; grants=0; rr_ptr=0, so master 0 has highest priority first. M_PSEL, M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA are all 0. S_PREADY, S_PSLVERR, S_PRDATA are all 0. Timeout counter is 0.
- FSM has three states: IDLE, SETUP, ACCESS. All outputs are decoded from registered state or registered latches; there are no combinational paths from S_* inputs to M_* outputs.
- IDLE:
  - If S_PSELx is nonzero, pick the first set bit at or after rr_ptr, wrapping around.
  - Latch that master's address, write strobe and write data.
  - Set grants to one-hot of the winner and go to SETUP.
  - If nothing is requested, stay in IDLE.
  - Latency: a request seen on edge N gives M_PSEL=1 in the cycle after edge N.
- SETUP: M_PSEL=1, M_PENABLE=0, for exactly one cycle, then go to ACCESS.
- ACCESS:
  - M_PSEL=1, M_PENABLE=1; the counter increments each cycle.
  - On M_PREADY=1, take the completion path below.
  - Timeout abort: if TIMEOUT is nonzero and the counter reaches TIMEOUT with M_PREADY low, the abort takes effect on the next cycle.
    - S_PREADY[g]=1 and S_PSLVERR[g]=1, with S_PRDATA slice = 0, for one cycle.
    - M_PSEL and M_PENABLE drop; go to IDLE.
- Completion:
  - Next cycle, S_PREADY[g]=1 for one cycle.
  - S_PRDATA slice g = registered M_PRDATA; S_PSLVERR=0.
  - M_PSEL and M_PENABLE drop; grants=0.
  - rr_ptr = (g+1) mod NUM_MASTERS, wrapping from NUM_MASTERS-1 to 0.
  - Return to IDLE.
- Back-to-back: there is always one IDLE cycle between transfers. Minimum transfer is 4 cycles: request, SETUP, ACCESS, response.
- Requester drops S_PSELx during its own transfer: this is a protocol violation. The downstream transfer still completes and the S_PREADY pulse is still issued; the scheduler ignores it.
- Simultaneous requests: only the round-robin winner is served. Losers stay pending and are not lost.
- Timeout counter is sized CNT_WIDTH; TIMEOUT >= 2**CNT_WIDTH is illegal (elaboration error). A timeout counts only ACCESS cycles and clears on every SETUP entry.
- NUM_MASTERS=1: grant is always to master 0; rr_ptr stays 0.
- Reset asserted mid-ACCESS: M_PSEL and M_PENABLE drop asynchronously and no S_PREADY is issued.

Decomposition:
- Shared header apb_sched_defs.v holds:
  - State encodings SCHED_IDLE=2'd0, SCHED_SETUP=2'd1, SCHED_ACCESS=2'd2.
  - The clog2-based index-width macro, shared with the interconnect.
- One sub-module, apb_rr_pick: a combinational rotating-priority picker. Inputs are reqs and rr_ptr; outputs are a one-hot winner and a binary index.
- The FSM, latches and counter live in apb_txn_scheduler.

Test Plan:
- Single read: M1 requests addr 0x0040. Expect M_PSEL high from cycle 1, M_PENABLE in cycle 2; slave returns 0xBEEF with PREADY in cycle 3 → S_PREADY[1] pulse in cycle 4, S_PRDATA[31:16]=0xBEEF, grants=0 after.
- Contention: all 4 request writes simultaneously with zero-wait slave → grants order 0001, 0010, 0100, 1000; each M_PWDATA matches its master; 4-cycle spacing.
- Fairness wrap: after serving M3, M0 and M3 both request → M0 is served first because rr_ptr wrapped to 0.
- Wait states: slave holds PREADY low for 5 ACCESS cycles → M_PADDR, M_PWDATA and M_PENABLE stay stable throughout; a single S_PREADY pulse follows.
- Timeout: TIMEOUT=8, slave never ready → after 8 ACCESS cycles, S_PREADY[g]=1 with S_PSLVERR[g]=1 and S_PRDATA=0; M_PSEL drops; a subsequent request proceeds normally.
- Reset mid-ACCESS: drive reset low asynchronously → all outputs 0 immediately; after release, master 0 wins a tie with master 2.

Source files
------------

// File: rtl/apb_txn_scheduler_pkg.sv
// rtl/apb_txn_scheduler_pkg.sv - shared state encodings and index-width helper
package apb_txn_scheduler_pkg;

  typedef enum logic [1:0] {
    SCHED_IDLE   = 2'd0,
    SCHED_SETUP  = 2'd1,
    SCHED_ACCESS = 2'd2
  } sched_state_e;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_txn_scheduler_if.sv
// rtl/apb_txn_scheduler_if.sv - core-side and downstream APB bundle of the scheduler
interface apb_txn_scheduler_if #(
  parameter int NUM_MASTERS = 4,
  parameter int BUS_WIDTH   = 16,
  parameter int DATA_WIDTH  = 16
);

  logic [NUM_MASTERS*BUS_WIDTH-1:0]  S_PADDR;
  logic [NUM_MASTERS-1:0]            S_PWRITE;
  logic [NUM_MASTERS-1:0]            S_PSELx;
  logic [NUM_MASTERS-1:0]            S_PENABLE;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] S_PWDATA;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] S_PRDATA;
  logic [NUM_MASTERS-1:0]            S_PREADY;
  logic [NUM_MASTERS-1:0]            S_PSLVERR;
  logic [BUS_WIDTH-1:0]              M_PADDR;
  logic                              M_PWRITE;
  logic                              M_PSEL;
  logic                              M_PENABLE;
  logic [DATA_WIDTH-1:0]             M_PWDATA;
  logic [DATA_WIDTH-1:0]             M_PRDATA;
  logic                              M_PREADY;
  logic [NUM_MASTERS-1:0]            grants;

  // master: the scheduler itself, which masters the downstream bus.
  modport master (
    input  S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA, M_PRDATA, M_PREADY,
    output S_PRDATA, S_PREADY, S_PSLVERR, M_PADDR, M_PWRITE, M_PSEL, M_PENABLE,
    output M_PWDATA, grants
  );

  modport slave (
    output S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA, M_PRDATA, M_PREADY,
    input  S_PRDATA, S_PREADY, S_PSLVERR, M_PADDR, M_PWRITE, M_PSEL, M_PENABLE,
    input  M_PWDATA, grants
  );

endinterface

// File: rtl/apb_txn_scheduler_rr_pick.sv
// rtl/apb_txn_scheduler_rr_pick.sv - combinational rotating-priority picker
module apb_rr_pick #(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_WIDTH   = 2
) (
  input  logic [NUM_MASTERS-1:0] reqs,
  input  logic [IDX_WIDTH-1:0]   rr_ptr,
  output logic [NUM_MASTERS-1:0] winner,
  output logic [IDX_WIDTH-1:0]   win_idx
);

  logic found;
  int   idx;

  // Scan from rr_ptr upward with wrap; the first requester seen wins.
  always_comb begin
    winner  = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int off = 0; off < NUM_MASTERS; off++) begin
      idx = (int'(rr_ptr) + off) % NUM_MASTERS;
      if (!found && reqs[idx]) begin
        found       = 1'b1;
        winner[idx] = 1'b1;
        win_idx     = IDX_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/apb_txn_scheduler.sv
// rtl/apb_txn_scheduler.sv - round-robin APB transaction scheduler with ACCESS timeout
module apb_txn_scheduler
  import apb_txn_scheduler_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int BUS_WIDTH   = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int TIMEOUT     = 255,
  parameter int CNT_WIDTH   = 8
) (
  input logic                 clk,
  input logic                 reset,
  apb_txn_scheduler_if.master bus
);

  localparam int                   IW       = idx_width(NUM_MASTERS);
  localparam logic [IW-1:0]        LAST_IDX = IW'(NUM_MASTERS - 1);
  localparam logic [CNT_WIDTH:0]   TO_LIMIT = (CNT_WIDTH + 1)'(TIMEOUT);
  localparam bit                   TO_EN    = (TIMEOUT != 0);

  if (NUM_MASTERS < 1) begin : g_chk_masters
    $error("apb_txn_scheduler: NUM_MASTERS must be at least 1");
  end
  if (TIMEOUT < 0 || longint'(TIMEOUT) >= (longint'(1) << CNT_WIDTH)) begin : g_chk_timeout
    $error("apb_txn_scheduler: TIMEOUT must be below 2**CNT_WIDTH");
  end

  sched_state_e                      state_q, state_d;
  logic [NUM_MASTERS-1:0]            grants_q, grants_d;
  logic [NUM_MASTERS-1:0]            pready_q, pready_d;
  logic [NUM_MASTERS-1:0]            pslverr_q, pslverr_d;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [IW-1:0]                     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]                     gidx_q, gidx_d;
  logic [BUS_WIDTH-1:0]              paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]             pwdata_q, pwdata_d;
  logic                              pwrite_q, pwrite_d;
  logic                              psel_q, psel_d;
  logic                              penable_q, penable_d;
  logic [CNT_WIDTH-1:0]              cnt_q, cnt_d;

  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [IW-1:0]          pick_idx;
  logic [CNT_WIDTH:0]     cnt_inc;
  logic                   timeout_hit;
  logic                   finish;
  logic                   finish_err;
  logic [DATA_WIDTH-1:0]  finish_data;

  // Requester PENABLE is observed only; the downstream phase is generated here.
  logic unused_penable;
  assign unused_penable = ^bus.S_PENABLE;

  apb_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_WIDTH   (IW)
  ) u_pick (
    .reqs    (bus.S_PSELx),
    .rr_ptr  (rr_ptr_q),
    .winner  (pick_onehot),
    .win_idx (pick_idx)
  );

  assign cnt_inc     = {1'b0, cnt_q} + 1'b1;
  assign timeout_hit = TO_EN && (cnt_inc == TO_LIMIT);

  always_comb begin
    state_d     = state_q;
    grants_d    = grants_q;
    pready_d    = '0;
    pslverr_d   = '0;
    prdata_d    = '0;
    rr_ptr_d    = rr_ptr_q;
    gidx_d      = gidx_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    cnt_d       = cnt_q;
    finish      = 1'b0;
    finish_err  = 1'b0;
    finish_data = '0;

    case (state_q)
      SCHED_IDLE: begin
        // The response-pulse cycle never arbitrates, so the finishing master
        // has a full cycle to drop its PSEL before the next pick.
        if (pready_q == '0 && bus.S_PSELx != '0) begin
          state_d  = SCHED_SETUP;
          grants_d = pick_onehot;
          gidx_d   = pick_idx;
          paddr_d  = bus.S_PADDR[int'(pick_idx)*BUS_WIDTH +: BUS_WIDTH];
          pwdata_d = bus.S_PWDATA[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
          pwrite_d = bus.S_PWRITE[pick_idx];
          psel_d   = 1'b1;
          cnt_d    = '0;
        end
      end
      SCHED_SETUP: begin
        state_d   = SCHED_ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      SCHED_ACCESS: begin
        if (bus.M_PREADY) begin
          finish      = 1'b1;
          finish_data = bus.M_PRDATA;
        end else if (timeout_hit) begin
          finish     = 1'b1;
          finish_err = 1'b1;
        end else begin
          cnt_d = cnt_inc[CNT_WIDTH-1:0];
        end
      end
      default: state_d = SCHED_IDLE;
    endcase

    // Aborted transfers also advance the pointer so a hung slave cannot
    // keep one requester at the head of the rotation.
    if (finish) begin
      state_d            = SCHED_IDLE;
      psel_d             = 1'b0;
      penable_d          = 1'b0;
      grants_d           = '0;
      pready_d[gidx_q]   = 1'b1;
      pslverr_d[gidx_q]  = finish_err;
      prdata_d[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH] = finish_data;
      rr_ptr_d           = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= SCHED_IDLE;
      grants_q  <= '0;
      pready_q  <= '0;
      pslverr_q <= '0;
      prdata_q  <= '0;
      rr_ptr_q  <= '0;
      gidx_q    <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grants_q  <= grants_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      rr_ptr_q  <= rr_ptr_d;
      gidx_q    <= gidx_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.M_PADDR   = paddr_q;
  assign bus.M_PWDATA  = pwdata_q;
  assign bus.M_PWRITE  = pwrite_q;
  assign bus.M_PSEL    = psel_q;
  assign bus.M_PENABLE = penable_q;
  assign bus.S_PREADY  = pready_q;
  assign bus.S_PSLVERR = pslverr_q;
  assign bus.S_PRDATA  = prdata_q;
  assign bus.grants    = grants_q;

endmodule

// File: tb/tb_apb_txn_scheduler.sv
// tb/tb_apb_txn_scheduler.sv - scoreboard bench for apb_txn_scheduler
module tb_apb_txn_scheduler;

  localparam int N  = 4;
  localparam int BW = 16;
  localparam int DW = 16;
  localparam int TO = 8;
  localparam int CW = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  apb_txn_scheduler_if #(.NUM_MASTERS(N), .BUS_WIDTH(BW), .DATA_WIDTH(DW)) bus ();

  apb_txn_scheduler #(
    .NUM_MASTERS (N),
    .BUS_WIDTH   (BW),
    .DATA_WIDTH  (DW),
    .TIMEOUT     (TO),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct {
    int          m;
    logic [BW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
  } setup_t;

  typedef struct {
    int            m;
    logic [DW-1:0] rdata;
    logic          err;
    int            acc;
  } resp_t;

  setup_t exp_setup[$];
  resp_t  exp_resp[$];
  int     setup_cyc[$];
  setup_t cur;

  int n_vec   = 0;
  int n_err   = 0;
  int cyc     = 0;
  int acc_cnt = 0;

  int            slave_wait  = 0;
  bit            slave_hang  = 1'b0;
  logic [DW-1:0] slave_rdata = '0;
  int            slave_cnt   = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [N-1:0] onehot(input int m);
    logic [N-1:0] v;
    v = '0;
    v[m] = 1'b1;
    return v;
  endfunction

  // Downstream slave: ready after slave_wait stalled ACCESS cycles, or never.
  always @(negedge clk) begin
    if (bus.M_PSEL && bus.M_PENABLE) begin
      slave_cnt++;
      bus.M_PREADY = !slave_hang && (slave_cnt > slave_wait);
    end else begin
      slave_cnt    = 0;
      bus.M_PREADY = 1'b0;
    end
    bus.M_PRDATA = slave_rdata;
  end

  // Monitor: pops the scoreboard whenever the DUT shows SETUP, ACCESS or a response.
  always @(negedge clk) begin
    if (reset) begin
      cyc++;
      if (bus.M_PSEL && !bus.M_PENABLE) begin
        if (exp_setup.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL setup_unexpected: grants=%b with nothing queued", bus.grants);
        end else begin
          cur = exp_setup.pop_front();
          setup_cyc.push_back(cyc);
          acc_cnt = 0;
          check("setup_grant", 64'(bus.grants), 64'(onehot(cur.m)));
          check("setup_paddr", 64'(bus.M_PADDR), 64'(cur.addr));
          check("setup_pwrite", 64'(bus.M_PWRITE), 64'(cur.wr));
          check("setup_pwdata", 64'(bus.M_PWDATA), 64'(cur.wdata));
        end
      end
      if (bus.M_PSEL && bus.M_PENABLE) begin
        acc_cnt++;
        check("access_paddr", 64'(bus.M_PADDR), 64'(cur.addr));
        check("access_pwdata", 64'(bus.M_PWDATA), 64'(cur.wdata));
        check("access_grant", 64'(bus.grants), 64'(onehot(cur.m)));
      end
      if (bus.S_PREADY != '0) begin
        if (exp_resp.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL resp_unexpected: S_PREADY=%b with nothing queued", bus.S_PREADY);
        end else begin
          resp_t e;
          e = exp_resp.pop_front();
          check("resp_pready", 64'(bus.S_PREADY), 64'(onehot(e.m)));
          check("resp_pslverr", 64'(bus.S_PSLVERR), e.err ? 64'(onehot(e.m)) : 64'd0);
          check("resp_prdata", 64'(bus.S_PRDATA), 64'(e.rdata) << (DW * e.m));
          check("resp_access_cycles", 64'(acc_cnt), 64'(e.acc));
          check("resp_psel_dropped", {63'd0, bus.M_PSEL | bus.M_PENABLE}, 64'd0);
          check("resp_grants_idle", 64'(bus.grants), 64'd0);
        end
      end
    end
  end

  task automatic req(input int m, input logic [BW-1:0] a, input logic w, input logic [DW-1:0] d);
    bus.S_PADDR[m*BW +: BW]  = a;
    bus.S_PWRITE[m]          = w;
    bus.S_PWDATA[m*DW +: DW] = d;
    bus.S_PSELx[m]           = 1'b1;
  endtask

  task automatic expect_xfer(input int m, input logic [BW-1:0] a, input logic w,
                             input logic [DW-1:0] d, input logic [DW-1:0] rd,
                             input logic err, input int acc);
    setup_t s;
    resp_t  r;
    s.m = m; s.addr = a; s.wr = w; s.wdata = d;
    r.m = m; r.rdata = rd; r.err = err; r.acc = acc;
    exp_setup.push_back(s);
    exp_resp.push_back(r);
  endtask

  // Requesters drop PSEL on seeing their S_PREADY; waits are bounded.
  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      bus.S_PSELx = bus.S_PSELx & ~bus.S_PREADY;
      if (bus.S_PSELx == '0 && bus.S_PREADY == '0 &&
          exp_setup.size() == 0 && exp_resp.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, {63'd0, ok}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.S_PADDR   = '0;
    bus.S_PWRITE  = '0;
    bus.S_PSELx   = '0;
    bus.S_PENABLE = '0;
    bus.S_PWDATA  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_psel", {63'd0, bus.M_PSEL}, 64'd0);
    check("rst_m_penable", {63'd0, bus.M_PENABLE}, 64'd0);
    check("rst_m_pwrite", {63'd0, bus.M_PWRITE}, 64'd0);
    check("rst_m_paddr", 64'(bus.M_PADDR), 64'd0);
    check("rst_m_pwdata", 64'(bus.M_PWDATA), 64'd0);
    check("rst_grants", 64'(bus.grants), 64'd0);
    check("rst_s_pready", 64'(bus.S_PREADY), 64'd0);
    check("rst_s_pslverr", 64'(bus.S_PSLVERR), 64'd0);
    check("rst_s_prdata", 64'(bus.S_PRDATA), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Contention: four writes at once, rr_ptr starts at 0.
    setup_cyc.delete();
    slave_rdata = 16'h0000;
    for (int i = 0; i < N; i++) begin
      req(i, 16'h0100 + 16'(i * 4), 1'b1, 16'h1000 + 16'(i));
      expect_xfer(i, 16'h0100 + 16'(i * 4), 1'b1, 16'h1000 + 16'(i), 16'h0000, 1'b0, 1);
    end
    wait_done("contention_done");
    check("contention_setups", 64'(setup_cyc.size()), 64'd4);
    if (setup_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++)
        check("contention_spacing", 64'(setup_cyc[i] - setup_cyc[i-1]), 64'd4);
    end

    // Fairness wrap: M3 was last, so M0 beats M3.
    slave_rdata = 16'h1234;
    req(0, 16'h0200, 1'b0, 16'h0000);
    req(3, 16'h0230, 1'b1, 16'h3333);
    expect_xfer(0, 16'h0200, 1'b0, 16'h0000, 16'h1234, 1'b0, 1);
    expect_xfer(3, 16'h0230, 1'b1, 16'h3333, 16'h1234, 1'b0, 1);
    wait_done("fairness_done");

    // Single read with cycle-exact latency.
    slave_rdata = 16'hBEEF;
    req(1, 16'h0040, 1'b0, 16'h0000);
    expect_xfer(1, 16'h0040, 1'b0, 16'h0000, 16'hBEEF, 1'b0, 1);
    @(negedge clk);
    check("read_no_comb_path", {63'd0, bus.M_PSEL}, 64'd0);
    @(negedge clk);
    check("read_setup_psel", {62'd0, bus.M_PSEL, bus.M_PENABLE}, 64'd2);
    @(negedge clk);
    check("read_access_penable", {62'd0, bus.M_PSEL, bus.M_PENABLE}, 64'd3);
    wait_done("read_done");
    check("read_grants_after", 64'(bus.grants), 64'd0);

    // Wait states: five stalled ACCESS cycles then ready.
    slave_wait  = 5;
    slave_rdata = 16'h0F0F;
    req(2, 16'h0080, 1'b1, 16'hA5A5);
    expect_xfer(2, 16'h0080, 1'b1, 16'hA5A5, 16'h0F0F, 1'b0, 6);
    wait_done("waitstate_done");
    slave_wait = 0;

    // Timeout: slave never ready, abort after TIMEOUT ACCESS cycles.
    slave_hang  = 1'b1;
    slave_rdata = 16'hDEAD;
    req(3, 16'h0300, 1'b0, 16'h0000);
    expect_xfer(3, 16'h0300, 1'b0, 16'h0000, 16'h0000, 1'b1, TO);
    wait_done("timeout_done");
    slave_hang  = 1'b0;
    slave_rdata = 16'h5555;
    req(0, 16'h0010, 1'b0, 16'h0000);
    expect_xfer(0, 16'h0010, 1'b0, 16'h0000, 16'h5555, 1'b0, 1);
    wait_done("after_timeout_done");

    // Reset while in ACCESS: outputs clear immediately, no response.
    slave_hang = 1'b1;
    begin
      setup_t s;
      bit reached;
      s.m = 1; s.addr = 16'h0044; s.wr = 1'b0; s.wdata = 16'h0000;
      exp_setup.push_back(s);
      req(1, 16'h0044, 1'b0, 16'h0000);
      reached = 1'b0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (bus.M_PENABLE) begin
          reached = 1'b1;
          break;
        end
      end
      check("rstmid_reached_access", {63'd0, reached}, 64'd1);
    end
    #2;
    reset       = 1'b0;
    bus.S_PSELx = '0;
    #1;
    check("rstmid_psel", {63'd0, bus.M_PSEL}, 64'd0);
    check("rstmid_penable", {63'd0, bus.M_PENABLE}, 64'd0);
    check("rstmid_grants", 64'(bus.grants), 64'd0);
    repeat (2) @(negedge clk);
    check("rstmid_no_pready", 64'(bus.S_PREADY), 64'd0);
    reset      = 1'b1;
    slave_hang = 1'b0;
    @(posedge clk);
    #1;
    slave_rdata = 16'h7777;
    req(0, 16'h0004, 1'b0, 16'h0000);
    req(2, 16'h0024, 1'b1, 16'h2222);
    expect_xfer(0, 16'h0004, 1'b0, 16'h0000, 16'h7777, 1'b0, 1);
    expect_xfer(2, 16'h0024, 1'b1, 16'h2222, 16'h7777, 1'b0, 1);
    wait_done("post_reset_tie_done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_vec++;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
